control_sequencer: RTL and testbench

//  Microcoded control unit for the 8-bit SAP CPU. Sequences fetch, decode and execute over the

---
 rtl/control_sequencer.sv | 169 ++++++++++++++++
 tb/tb_control_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit SAP CPU: fetch/decode/execute sequencing with a
// run gate between instructions and a per-opcode execute microcode table.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int MAX_STEPS    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  input  logic                    flag_zero,
  input  logic                    flag_carry,
  output logic [19:0]             control_word,
  output logic [2:0]              state_o,
  output logic [3:0]              step_o
);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_WAIT     = 3'd1,
    S_FETCH_0  = 3'd2,
    S_FETCH_1  = 3'd3,
    S_DECODE_0 = 3'd4,
    S_DECODE_1 = 3'd5,
    S_EXECUTE  = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  localparam logic [19:0] CW_HALT      = 20'h80000;
  localparam logic [19:0] CW_LAST      = 20'h40000;
  localparam logic [19:0] CW_PC_EN     = 20'h20000;
  localparam logic [19:0] CW_LOAD_PC   = 20'h10000;
  localparam logic [19:0] CW_OE_PC     = 20'h08000;
  localparam logic [19:0] CW_LOAD_IR   = 20'h04000;
  localparam logic [19:0] CW_OE_IR     = 20'h02000;
  localparam logic [19:0] CW_LOAD_MAR  = 20'h01000;
  localparam logic [19:0] CW_LOAD_RAM  = 20'h00800;
  localparam logic [19:0] CW_OE_RAM    = 20'h00400;
  localparam logic [19:0] CW_OE_ALU    = 20'h00080;
  localparam logic [19:0] CW_CHK_ZERO  = 20'h00040;
  localparam logic [19:0] CW_CHK_CARRY = 20'h00020;
  localparam logic [19:0] CW_LOAD_A    = 20'h00010;
  localparam logic [19:0] CW_OE_A      = 20'h00008;
  localparam logic [19:0] CW_LOAD_B    = 20'h00004;
  localparam logic [19:0] CW_LOAD_O    = 20'h00001;
  localparam logic [19:0] CW_ADDR      = CW_OE_IR | CW_LOAD_MAR;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC   = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUTM = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUTA = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(15);

  state_t                  state, state_next;
  logic [3:0]              step, step_next;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic                    z_q, c_q;
  logic [19:0]             ucode;
  logic [1:0]              alu_sel;
  logic                    last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RESET;
      step     <= '0;
      opcode_q <= OP_NOP;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state <= state_next;
      step  <= step_next;
      if (state == S_DECODE_0) opcode_q <= opcode_in;
      if (state == S_DECODE_1) begin
        z_q <= flag_zero;
        c_q <= flag_carry;
      end
    end
  end

  // Execute microcode table, indexed by latched opcode and microstep.
  always_comb begin
    ucode   = '0;
    alu_sel = 2'(opcode_q - OP_ADD);
    case (opcode_q)
      OP_LDA, OP_LDB, OP_STA, OP_OUTM: begin
        if (step == 4'd0) ucode = CW_ADDR;
        else if (step == 4'd1) begin
          case (opcode_q)
            OP_LDA:  ucode = CW_OE_RAM | CW_LOAD_A | CW_LAST;
            OP_LDB:  ucode = CW_OE_RAM | CW_LOAD_B | CW_LAST;
            OP_STA:  ucode = CW_OE_A | CW_LOAD_RAM | CW_LAST;
            default: ucode = CW_OE_RAM | CW_LOAD_O | CW_LAST;
          endcase
        end
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        case (step)
          4'd0:    ucode = CW_ADDR;
          4'd1:    ucode = CW_OE_RAM | CW_LOAD_B;
          4'd2:    ucode = CW_OE_ALU | CW_LOAD_A | CW_CHK_ZERO | CW_CHK_CARRY | CW_LAST
                           | {10'd0, alu_sel, 8'd0};
          default: ucode = '0;
        endcase
      end
      OP_LDI:  ucode = CW_OE_IR | CW_LOAD_A | CW_LAST;
      OP_JMP:  ucode = CW_OE_IR | CW_LOAD_PC | CW_LAST;
      OP_JC:   ucode = c_q ? (CW_OE_IR | CW_LOAD_PC | CW_LAST) : CW_LAST;
      OP_JZ:   ucode = z_q ? (CW_OE_IR | CW_LOAD_PC | CW_LAST) : CW_LAST;
      OP_OUTA: ucode = CW_OE_A | CW_LOAD_O | CW_LAST;
      OP_HLT:  ucode = CW_HALT | CW_LAST;
      default: ucode = CW_LAST;
    endcase
  end

  // Watchdog: the final allowed microstep always ends the instruction.
  assign last = ucode[18] | (step == 4'(MAX_STEPS - 1));

  always_comb begin
    state_next   = state;
    step_next    = step;
    control_word = '0;
    case (state)
      S_RESET:    state_next = S_WAIT;
      S_WAIT:     if (run) state_next = S_FETCH_0;
      S_FETCH_0: begin
        control_word = CW_OE_PC | CW_LOAD_MAR;
        state_next   = S_FETCH_1;
      end
      S_FETCH_1: begin
        control_word = CW_OE_RAM | CW_LOAD_IR | CW_PC_EN;
        state_next   = S_DECODE_0;
      end
      S_DECODE_0: begin
        step_next  = '0;
        state_next = S_DECODE_1;
      end
      S_DECODE_1: state_next = S_EXECUTE;
      S_EXECUTE: begin
        control_word = ucode | (last ? CW_LAST : 20'd0);
        if (last) begin
          step_next  = '0;
          state_next = (opcode_q == OP_HLT) ? S_HALT : S_WAIT;
        end else begin
          step_next = step + 4'd1;
        end
      end
      S_HALT:     control_word = CW_HALT;
      default:    state_next = S_RESET;
    endcase
  end

  assign state_o = state;
  assign step_o  = step;

  a_bus_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({control_word[15], control_word[13], control_word[10],
              control_word[7], control_word[3], control_word[1]}));

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class through
// fetch/decode/execute and checks state, microstep and control word.
module tb_control_sequencer;

  localparam logic [19:0] HALT = 20'h80000, LAST = 20'h40000, PC_EN = 20'h20000;
  localparam logic [19:0] LOAD_PC = 20'h10000, OE_PC = 20'h08000, LOAD_IR = 20'h04000;
  localparam logic [19:0] OE_IR = 20'h02000, LOAD_MAR = 20'h01000, OE_RAM = 20'h00400;
  localparam logic [19:0] ALU1 = 20'h00200, ALU0 = 20'h00100, OE_ALU = 20'h00080;
  localparam logic [19:0] CZ = 20'h00040, CC = 20'h00020, LOAD_A = 20'h00010;
  localparam logic [19:0] LOAD_B = 20'h00004;
  localparam logic [19:0] ALU_DONE = OE_ALU | LOAD_A | CZ | CC | LAST;

  localparam logic [3:0] OP_ADD = 4'd3, OP_SUB = 4'd4, OP_AND = 4'd5, OP_LDI = 4'd8;
  localparam logic [3:0] OP_JC = 4'd10, OP_JZ = 4'd11, OP_UNDEF = 4'd12, OP_HLT = 4'd15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [3:0]  opcode_in;
  logic        flag_zero, flag_carry;
  logic [19:0] control_word;
  logic [2:0]  state_o;
  logic [3:0]  step_o;

  int n_checks = 0;
  int n_fail   = 0;

  control_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .opcode_in    (opcode_in),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .control_word (control_word),
    .state_o      (state_o),
    .step_o       (step_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic [3:0] sp,
                        input logic [19:0] cw);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_step"},  32'(step_o),  32'(sp));
    chk({tag, "_cw"},    32'(control_word), 32'(cw));
  endtask

  // Starts from a negedge in WAIT; returns at the negedge of execute microstep 0.
  task automatic fetch_decode(input logic [3:0] op, input logic z, input logic c);
    run = 1'b1; opcode_in = op; flag_zero = z; flag_carry = c;
    cyc(); chk_st("f0", 3'd2, 4'd0, OE_PC | LOAD_MAR);
    run = 1'b0;
    cyc(); chk("f1_cw", 32'(control_word), 32'(OE_RAM | LOAD_IR | PC_EN));
    cyc(); chk_st("d0", 3'd4, 4'd0, 20'd0);
    cyc(); chk_st("d1", 3'd5, 4'd0, 20'd0);
    cyc();
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_checks++;
      assert ($onehot0({control_word[15], control_word[13], control_word[10],
                        control_word[7], control_word[3], control_word[1]})) else begin
        n_fail++;
        $error("FAIL bus_excl: observed cw %0h expected at most one oe bit", control_word);
      end
    end
  end

  initial begin
    reset_n = 1'b0; run = 1'b1; opcode_in = OP_LDI; flag_zero = 1'b0; flag_carry = 1'b0;

    // Reset and an LDI instruction
    cyc(); chk_st("reset", 3'd0, 4'd0, 20'd0);
    reset_n = 1'b1;
    cyc(); chk_st("wait0", 3'd1, 4'd0, 20'd0);
    fetch_decode(OP_LDI, 1'b0, 1'b0);
    chk_st("ldi_ex", 3'd6, 4'd0, OE_IR | LOAD_A | LAST);

    // Run gate holds in WAIT
    for (int i = 0; i < 10; i++) begin
      cyc(); chk_st("wait_hold", 3'd1, 4'd0, 20'd0);
    end

    // SUB then AND: three-step ALU ops with alu_op on the last step
    fetch_decode(OP_SUB, 1'b0, 1'b0);
    chk_st("sub_ms0", 3'd6, 4'd0, OE_IR | LOAD_MAR);
    cyc(); chk_st("sub_ms1", 3'd6, 4'd1, OE_RAM | LOAD_B);
    cyc(); chk_st("sub_ms2", 3'd6, 4'd2, ALU_DONE | ALU0);
    cyc(); chk_st("sub_wait", 3'd1, 4'd0, 20'd0);
    fetch_decode(OP_AND, 1'b0, 1'b0);
    cyc(); cyc(); chk_st("and_ms2", 3'd6, 4'd2, ALU_DONE | ALU1);
    cyc();

    // Conditional jumps use flags latched in DECODE_1 only
    fetch_decode(OP_JC, 1'b0, 1'b0);
    chk_st("jc_nc", 3'd6, 4'd0, LAST);
    cyc();
    fetch_decode(OP_JC, 1'b0, 1'b1);
    flag_carry = 1'b0;
    #1 chk("jc_c_cw", 32'(control_word), 32'(OE_IR | LOAD_PC | LAST));
    cyc();
    fetch_decode(OP_JZ, 1'b1, 1'b0);
    chk("jz_z_cw", 32'(control_word), 32'(OE_IR | LOAD_PC | LAST));
    cyc();
    fetch_decode(OP_JZ, 1'b0, 1'b1);
    chk("jz_nz_cw", 32'(control_word), 32'(LAST));
    cyc();

    // Asynchronous reset in the middle of ADD, then the undefined opcode
    fetch_decode(OP_ADD, 1'b0, 1'b0);
    chk_st("add_ms0", 3'd6, 4'd0, OE_IR | LOAD_MAR);
    cyc(); chk_st("add_ms1", 3'd6, 4'd1, OE_RAM | LOAD_B);
    #2 reset_n = 1'b0;
    #1 chk_st("async_rst", 3'd0, 4'd0, 20'd0);
    cyc(); reset_n = 1'b1;
    cyc(); chk_st("wait_after_rst", 3'd1, 4'd0, 20'd0);
    fetch_decode(OP_UNDEF, 1'b0, 1'b0);
    chk_st("undef_ex", 3'd6, 4'd0, LAST);
    cyc(); chk_st("undef_wait", 3'd1, 4'd0, 20'd0);

    // HLT sticks until reset regardless of run
    fetch_decode(OP_HLT, 1'b0, 1'b0);
    chk_st("hlt_ex", 3'd6, 4'd0, HALT | LAST);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); chk_st("halt_hold", 3'd7, 4'd0, HALT);
    end
    #2 reset_n = 1'b0;
    #1 chk_st("halt_rst", 3'd0, 4'd0, 20'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
